// File: rtl/rgb_frame_sink.sv
// End-of-pipe RGB frame checker: tracks x/y within a frame, accumulates a rotate-XOR
// signature and per-channel sum/min/max, and publishes them with a one-cycle done pulse.
module rgb_frame_sink #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int SUM_W    = 27
) (
   input  logic             pixelclk,
   input  logic             reset_n,
   input  logic [23:0]      i_rgb,
   input  logic             i_data_valid,
   input  logic             i_sof,
   output logic             o_busy,
   output logic             o_frame_done,
   output logic             o_sof_err,
   output logic [15:0]      o_frame_cnt,
   output logic [31:0]      o_sig,
   output logic [SUM_W-1:0] o_sum_r,
   output logic [SUM_W-1:0] o_sum_g,
   output logic [SUM_W-1:0] o_sum_b,
   output logic [23:0]      o_rgb_min,
   output logic [23:0]      o_rgb_max
);

   localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic [0:0]       r_state;
   logic [X_W-1:0]   r_x;
   logic [Y_W-1:0]   r_y;
   logic [31:0]      r_sig;
   logic [SUM_W-1:0] r_sum_r, r_sum_g, r_sum_b;
   logic [23:0]      r_min, r_max;

   logic             r_done, r_err;
   logic [15:0]      r_cnt;
   logic [31:0]      r_res_sig;
   logic [SUM_W-1:0] r_res_sum_r, r_res_sum_g, r_res_sum_b;
   logic [23:0]      r_res_min, r_res_max;

   logic             w_accept, w_last;
   logic [X_W-1:0]   w_bx;
   logic [Y_W-1:0]   w_by;
   logic [31:0]      w_sig_nx;
   logic [SUM_W-1:0] w_sum_r_nx, w_sum_g_nx, w_sum_b_nx;
   logic [23:0]      w_min_nx, w_max_nx;

   function automatic logic [23:0] chan_min(input logic [23:0] a, input logic [23:0] b);
      logic [23:0] res;
      res = '0;
      for (int k = 0; k < 3; k++)
         res[8*k +: 8] = (a[8*k +: 8] < b[8*k +: 8]) ? a[8*k +: 8] : b[8*k +: 8];
      return res;
   endfunction

   function automatic logic [23:0] chan_max(input logic [23:0] a, input logic [23:0] b);
      logic [23:0] res;
      res = '0;
      for (int k = 0; k < 3; k++)
         res[8*k +: 8] = (a[8*k +: 8] > b[8*k +: 8]) ? a[8*k +: 8] : b[8*k +: 8];
      return res;
   endfunction

   // An SOF beat is always pixel (0,0) and seeds the accumulators, in IDLE or ACTIVE alike.
   assign w_accept   = i_data_valid && (i_sof || (r_state == ST_ACTIVE));
   assign w_bx       = i_sof ? '0 : r_x;
   assign w_by       = i_sof ? '0 : r_y;
   assign w_last     = w_accept && (w_bx == X_LAST) && (w_by == Y_LAST);
   assign w_sig_nx   = i_sof ? {8'd0, i_rgb} : ({r_sig[30:0], r_sig[31]} ^ {8'd0, i_rgb});
   assign w_sum_r_nx = (i_sof ? '0 : r_sum_r) + SUM_W'(i_rgb[23:16]);
   assign w_sum_g_nx = (i_sof ? '0 : r_sum_g) + SUM_W'(i_rgb[15:8]);
   assign w_sum_b_nx = (i_sof ? '0 : r_sum_b) + SUM_W'(i_rgb[7:0]);
   assign w_min_nx   = i_sof ? i_rgb : chan_min(r_min, i_rgb);
   assign w_max_nx   = i_sof ? i_rgb : chan_max(r_max, i_rgb);

   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_sig       <= '0;
         r_sum_r     <= '0;
         r_sum_g     <= '0;
         r_sum_b     <= '0;
         r_min       <= 24'hFFFFFF;
         r_max       <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_cnt       <= '0;
         r_res_sig   <= '0;
         r_res_sum_r <= '0;
         r_res_sum_g <= '0;
         r_res_sum_b <= '0;
         r_res_min   <= 24'hFFFFFF;
         r_res_max   <= '0;
      end else begin
         // NOTE: non-blocking throughout so every branch sees the pre-edge state.
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (w_accept) begin
            r_err <= (r_state == ST_ACTIVE) && i_sof;
            if (w_last) begin
               r_res_sig   <= w_sig_nx;
               r_res_sum_r <= w_sum_r_nx;
               r_res_sum_g <= w_sum_g_nx;
               r_res_sum_b <= w_sum_b_nx;
               r_res_min   <= w_min_nx;
               r_res_max   <= w_max_nx;
               r_cnt       <= r_cnt + 16'd1;
               r_done      <= 1'b1;
               r_state     <= ST_IDLE;
               r_x         <= '0;
               r_y         <= '0;
            end else begin
               r_sig   <= w_sig_nx;
               r_sum_r <= w_sum_r_nx;
               r_sum_g <= w_sum_g_nx;
               r_sum_b <= w_sum_b_nx;
               r_min   <= w_min_nx;
               r_max   <= w_max_nx;
               r_state <= ST_ACTIVE;
               if (w_bx == X_LAST) begin
                  r_x <= '0;
                  r_y <= w_by + Y_W'(1);
               end else begin
                  r_x <= w_bx + X_W'(1);
                  r_y <= w_by;
               end
            end
         end
      end
   end

   assign o_busy       = (r_state == ST_ACTIVE);
   assign o_frame_done = r_done;
   assign o_sof_err    = r_err;
   assign o_frame_cnt  = r_cnt;
   assign o_sig        = r_res_sig;
   assign o_sum_r      = r_res_sum_r;
   assign o_sum_g      = r_res_sum_g;
   assign o_sum_b      = r_res_sum_b;
   assign o_rgb_min    = r_res_min;
   assign o_rgb_max    = r_res_max;

endmodule
